// File: rtl/fifo_pack_reader_if.sv
// Bundle between fifo_pack_reader and its neighbours: the async FIFO read port plus the packed
// valid/ready output stream. m_chksum exists only when FIFO_PACK_CHKSUM_EN is defined.
interface fifo_pack_reader_if #(
  parameter int WIDTH = 8,
  parameter int PACK  = 4
) ();
  logic                    fifo_empty;
  logic                    fifo_rd_EN;
  logic [WIDTH-1:0]        fifo_data_out;
  logic                    fifo_Dout_valid;
  logic [WIDTH*PACK-1:0]   m_data;
  logic [PACK-1:0]         m_keep;
  logic                    m_valid;
  logic                    m_ready;
`ifdef FIFO_PACK_CHKSUM_EN
  logic [WIDTH-1:0]        m_chksum;
`endif

  // Handshake: a word transfers on a rising clk edge where m_valid && m_ready are both high;
  // m_valid never drops and m_data/m_keep never change until that transfer happens.
  modport master (
    input  fifo_empty, fifo_data_out, fifo_Dout_valid, m_ready,
    output fifo_rd_EN, m_data, m_keep, m_valid
`ifdef FIFO_PACK_CHKSUM_EN
    , output m_chksum
`endif
  );

  modport slave (
    output fifo_empty, fifo_data_out, fifo_Dout_valid, m_ready,
    input  fifo_rd_EN, m_data, m_keep, m_valid
`ifdef FIFO_PACK_CHKSUM_EN
    , input m_chksum
`endif
  );
endinterface

// File: rtl/fifo_pack_reader.sv
// Read-domain FIFO consumer: packs PACK entries into one output word, with flush for partial words.
// Optional FIFO_PACK_CHKSUM_EN adds m_chksum, the mod-2^WIDTH sum of the valid lanes.
module fifo_pack_reader #(
  parameter int WIDTH = 8,
  parameter int PACK  = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  output logic err,
  output logic state_dbg,
  fifo_pack_reader_if.master bus
);

  localparam int CW = $clog2(PACK + 1);
  localparam int LW = $clog2(PACK);

  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

  state_t        state;
  logic [CW-1:0] issued_cnt;
  logic [CW-1:0] cap_cnt;
  logic          flush_pend;
  logic          armed;
  logic          capture;
  logic          last_lane;
  logic          nothing_started;

  assign state_dbg       = (state == HOLD);
  assign bus.fifo_rd_EN  = (state == FILL) && !bus.fifo_empty && !flush_pend &&
                           (issued_cnt < CW'(PACK));
  assign capture         = (state == FILL) && bus.fifo_Dout_valid && (cap_cnt < issued_cnt);
  assign last_lane       = capture && (cap_cnt == CW'(PACK - 1));
  assign nothing_started = (cap_cnt == '0) && (issued_cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= FILL;
      issued_cnt  <= '0;
      cap_cnt     <= '0;
      flush_pend  <= 1'b0;
      armed       <= 1'b0;
      err         <= 1'b0;
      bus.m_valid <= 1'b0;
      bus.m_data  <= '0;
      bus.m_keep  <= '0;
`ifdef FIFO_PACK_CHKSUM_EN
      bus.m_chksum <= '0;
`endif
    end else begin
      // armed stays low for the first clk out of reset so a straggling read is not an error
      armed <= 1'b1;
      if (armed && bus.fifo_Dout_valid && (cap_cnt == issued_cnt)) begin
        err <= 1'b1;
      end
      if (bus.fifo_rd_EN) begin
        issued_cnt <= issued_cnt + CW'(1);
      end

      case (state)
        FILL: begin
          if (capture) begin
            bus.m_data[WIDTH*int'(cap_cnt[LW-1:0]) +: WIDTH] <= bus.fifo_data_out;
            bus.m_keep[cap_cnt[LW-1:0]]                      <= 1'b1;
            cap_cnt                                          <= cap_cnt + CW'(1);
`ifdef FIFO_PACK_CHKSUM_EN
            bus.m_chksum <= bus.m_chksum + bus.fifo_data_out;
`endif
          end
          // A full word wins over any flush arriving in the same cycle.
          if (last_lane) begin
            state       <= HOLD;
            bus.m_valid <= 1'b1;
            flush_pend  <= 1'b0;
          end else if (flush_pend) begin
            if (cap_cnt == issued_cnt) begin
              state       <= HOLD;
              bus.m_valid <= 1'b1;
            end
          end else if (flush && !nothing_started) begin
            flush_pend <= 1'b1;
          end
        end

        HOLD: begin
          if (bus.m_ready) begin
            state       <= FILL;
            bus.m_valid <= 1'b0;
            issued_cnt  <= '0;
            cap_cnt     <= '0;
            flush_pend  <= 1'b0;
            bus.m_data  <= '0;
            bus.m_keep  <= '0;
`ifdef FIFO_PACK_CHKSUM_EN
            bus.m_chksum <= '0;
`endif
          end
        end

        default: state <= FILL;
      endcase
    end
  end

endmodule
